// File: rtl/sliding_mean_mc.sv
// Per-channel sliding-window mean (W = 2^win_log2) with koef/8 scaling and saturation, plus the window-centre sample.
// Latency 2 cycles in_valid -> out_valid, 1 sample/cycle; no backpressure, and a window change drops that cycle's sample.
module sliding_mean_mc #(
    parameter  int WIDTH        = 16,
    parameter  int MAX_WIN_LOG2 = 6,
    parameter  int NCH          = 2,
    parameter  int KOEF_W       = 7,
    localparam int WL_W         = $clog2(MAX_WIN_LOG2 + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [WL_W-1:0]      win_log2,
    input  logic [KOEF_W-1:0]    koef,
    output logic                 out_valid,
    output logic [NCH*WIDTH-1:0] out_mean,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic                 out_full
);
    localparam int DEPTH  = 1 << MAX_WIN_LOG2;
    localparam int PW     = MAX_WIN_LOG2;
    localparam int ACC_W  = WIDTH + MAX_WIN_LOG2;
    localparam int PROD_W = ACC_W + KOEF_W + 1;
    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = -SAT_MAX - PROD_W'(1);

    logic [WIDTH-1:0]        mem [NCH][DEPTH];
    logic [PW-1:0]           wptr;
    logic [PW:0]             fcnt;
    logic [PW:0]             wsize;
    logic [WL_W-1:0]         win_r;
    logic [WL_W-1:0]         win_clamp;
    logic                    win_chg;
    logic                    accept;
    logic                    filling;
    logic                    valid_d1;
    logic signed [ACC_W-1:0] acc     [NCH];
    logic signed [ACC_W-1:0] acc_nxt [NCH];
    logic signed [ACC_W-1:0] mean    [NCH];
    logic signed [PROD_W-1:0] prod   [NCH];
    logic [WIDTH-1:0]        x       [NCH];
    logic [WIDTH-1:0]        oldest  [NCH];
    logic [WIDTH-1:0]        centre  [NCH];
    logic [WIDTH-1:0]        data_d1 [NCH];
    logic [WIDTH-1:0]        sat     [NCH];

    always_comb begin
        win_clamp = (win_log2 > WL_W'(MAX_WIN_LOG2)) ? WL_W'(MAX_WIN_LOG2) : win_log2;
        win_chg   = (win_clamp != win_r);
        accept    = in_valid && !win_chg;
        wsize     = (PW + 1)'(1) << win_r;
        filling   = (fcnt < wsize);
    end

    // Stage-1 datapath: both buffer reads happen before this cycle's write.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            x[c] = in_data[c*WIDTH +: WIDTH];
`ifndef SYNTHESIS
            if ($isunknown(in_data[c*WIDTH +: WIDTH])) x[c] = '0;
`endif
            oldest[c]  = mem[c][wptr - wsize[PW-1:0]];
            centre[c]  = (win_r == '0) ? x[c] : mem[c][wptr - wsize[PW:1]];
            acc_nxt[c] = acc[c] + ACC_W'($signed(x[c]))
                         - (filling ? ACC_W'(0) : ACC_W'($signed(oldest[c])));
        end
    end

    // Stage 2 reads acc/win_r/fcnt before the next accept or window change lands.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            mean[c] = acc[c] >>> win_r;
            prod[c] = (PROD_W'(mean[c]) * PROD_W'($signed({1'b0, koef}))) >>> 3;
            if (prod[c] > SAT_MAX)
                sat[c] = WIDTH'(SAT_MAX);
            else if (prod[c] < SAT_MIN)
                sat[c] = WIDTH'(SAT_MIN);
            else
                sat[c] = WIDTH'(prod[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            fcnt      <= '0;
            win_r     <= win_clamp;
            valid_d1  <= 1'b0;
            out_valid <= 1'b0;
            out_mean  <= '0;
            out_data  <= '0;
            out_full  <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                acc[c]     <= '0;
                data_d1[c] <= '0;
                for (int i = 0; i < DEPTH; i++) mem[c][i] <= '0;
            end
        end else begin
            out_valid <= valid_d1;
            if (valid_d1) begin
                out_full <= (fcnt == wsize);
                for (int c = 0; c < NCH; c++) begin
                    out_mean[c*WIDTH +: WIDTH] <= sat[c];
                    out_data[c*WIDTH +: WIDTH] <= data_d1[c];
                end
            end
            valid_d1 <= accept;
            if (win_chg) begin
                win_r <= win_clamp;
                fcnt  <= '0;
                for (int c = 0; c < NCH; c++) acc[c] <= '0;
            end else if (in_valid) begin
                wptr <= wptr + PW'(1);
                if (filling) fcnt <= fcnt + (PW + 1)'(1);
                for (int c = 0; c < NCH; c++) begin
                    mem[c][wptr] <= x[c];
                    acc[c]       <= acc_nxt[c];
                    data_d1[c]   <= centre[c];
                end
            end
        end
    end
endmodule

// File: doc/sliding_mean_mc.md
# sliding_mean_mc

Multi-channel, runtime-configurable sliding-window mean estimator for the Rx correlator chain. Per channel it keeps a running sum over the last W = 2^win_log2 accepted samples, outputs the scaled mean (koef in Q(KOEF_W-3).3), and outputs the window-centre sample aligned with that mean. It sits between the sample front-end and the xcorr threshold comparator, and it succeeds the single-channel fixed-window mean block with a valid handshake, selectable window and saturation.

## Interface
- WIDTH, 16: signed sample width per channel
- MAX_WIN_LOG2, 6: log2 of maximum window (buffer depth 2^MAX_WIN_LOG2)
- NCH, 2: channel count (I/Q default)
- KOEF_W, 7: unsigned scale-factor width, 3 fractional bits
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  sample strobe; all channels advance together
- in_data  in  NCH*WIDTH  signed samples, channel c at bits [c*WIDTH +: WIDTH]
- win_log2  in  $clog2(MAX_WIN_LOG2+1)  window select; values > MAX_WIN_LOG2 clamp to MAX_WIN_LOG2
- koef  in  KOEF_W  unsigned scale, value/8
- out_valid  out  1  output strobe
- out_mean  out  NCH*WIDTH  signed scaled mean per channel
- out_data  out  NCH*WIDTH  window-centre sample per channel
- out_full  out  1  window filled; mean covers W samples

## Operation
- Per channel: circular buffer of 2^MAX_WIN_LOG2 x WIDTH, shared write pointer wptr (MAX_WIN_LOG2 bits, wraps modulo depth), advanced only on in_valid.
- Oldest sample = buf[wptr - W], centre sample = buf[wptr - W/2] (W=1: centre is the current input), read before the write.
- Accumulator per channel: signed WIDTH+MAX_WIN_LOG2 bits; overflow is impossible by construction.
- Fill counter fcnt (0..W): increments on in_valid until it reaches W.
- On in_valid: if fcnt < W, acc += x; else acc += x - oldest.
- mean = acc >>> win_log2 (arithmetic, floor toward -inf); it is partial while filling.
- scaled = (mean * koef) >>> 3, signed; saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Window change: the effective window register is updated when clamped win_log2 differs from it. In that same cycle acc and fcnt clear to 0. The buffer is not cleared. wptr continues. Any in_valid in that cycle is dropped and produces no out_valid.
- koef is sampled in pipeline stage 2 and may change at any time.
- Buffer contents are zeroed at rst.
- X on in_data with in_valid = 1 is treated as 0 in simulation only.

## Timing
- Stage 1 (edge after in_valid = 1): buffer write, acc/fcnt update, centre sample registered, valid_d1 set.
- Stage 2 (next edge): shift, multiply, saturate, registered into out_mean/out_data. out_valid = valid_d1.
- Latency is 2 cycles from in_valid to out_valid. Throughput is 1 sample/cycle. in_valid gaps of any length do not alter state.
- out_full rises with the out_valid whose mean includes the W-th sample, and stays high until rst or a window change. It deasserts with the first post-change out_valid.
- Reset values: out_valid=0, out_mean=0, out_data=0, out_full=0, acc=0, fcnt=0, wptr=0. The effective window loads clamped win_log2 during rst.
- A rst mid-stream cancels in-flight pipeline outputs. No out_valid appears for 2 cycles after rst deasserts unless in_valid is given.
- wptr wrap at 2^MAX_WIN_LOG2 - 1 -> 0 is seamless. Sums stay correct across the wrap.

## Test plan
- Reset: hold rst 3 cycles with random inputs -> all outputs 0. First in_valid after release -> out_valid exactly 2 cycles later.
- Constant fill: win_log2=3, koef=8, ch0=100, ch1=-100, 20 consecutive valids -> means 12,25,...,100 / -13,-25,...,-100. out_full high from the 8th output onward. out_data equals the input from 4 samples earlier.
- Saturation and floor: win_log2=0, koef=127, ch0=30000 -> out_mean 32767. ch1=-30000 -> -32768. win_log2=1 with samples -1, 0 -> mean -1.
- Gapped stream and wrap: win_log2=6, in_valid 50% random, 300 random samples -> out_mean bit-exact against a reference model. Includes ≥4 pointer wraps.
- Window change mid-stream: after out_full with win_log2=2, switch to 4 -> out_full drops, acc restarts. It is full again after 16 valids, and those means match the reference model.
- Clamp and rst mid-operation: win_log2 = MAX+1 behaves as MAX. Assert rst while valids are in flight -> outputs 0 next cycle, no stale out_valid.
